// File: rtl/gumnut_pkg.sv
// Shared types and sizes for the gumnut program-counter sequencer.
package gumnut_pkg;

  localparam int unsigned PC_W        = 12;
  localparam int unsigned DISP_W      = 8;
  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1);

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } seq_state_e;

  // Source selection for the next program counter value
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_INC    = 3'd1,
    SEL_TARGET = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_STACK  = 3'd4,
    SEL_SAVED  = 3'd5,
    SEL_INT    = 3'd6
  } pc_sel_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC multiplexer with the signed relative-branch adder.
module pc_next_calc
  import gumnut_pkg::*;
#(
  parameter logic [11:0] INT_VEC = 12'h001
) (
  input  pc_sel_e     sel,
  input  logic [11:0] pc,
  input  logic [11:0] target,
  input  logic [7:0]  disp,
  input  logic [11:0] stack_pc,
  input  logic [11:0] saved_pc,
  output logic [11:0] pc_next
);

  logic [11:0] disp_ext;

  // Two's complement displacement widened to PC width; sum wraps mod 4096
  assign disp_ext = {{(PC_W - DISP_W){disp[DISP_W-1]}}, disp};

  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_INC:    pc_next = pc + 12'd1;
      SEL_TARGET: pc_next = target;
      SEL_BRANCH: pc_next = pc + disp_ext;
      SEL_STACK:  pc_next = stack_pc;
      SEL_SAVED:  pc_next = saved_pc;
      SEL_INT:    pc_next = INT_VEC;
      default:    pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: jumps, calls/returns, branches, interrupts.
// Interrupt support is compiled in only when PC_SEQ_INT_EN is defined.
module pc_sequencer
  import gumnut_pkg::*;
#(
  parameter logic [11:0] RESET_VEC = 12'h000,
  parameter logic [11:0] INT_VEC   = 12'h001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        jmp_i,
  input  logic        jsb_i,
  input  logic        ret_i,
  input  logic        br_taken_i,
  input  logic [11:0] target_i,
  input  logic [7:0]  disp_i,
  input  logic        reti_i,
  input  logic        ien_set_i,
  input  logic        ien_clr_i,
  input  logic        int_req_i,
  input  logic [11:0] stack_pc_i,
  output logic [11:0] pc_o,
  output logic        push_o,
  output logic        pop_o,
  output logic [11:0] push_pc_o,
  output logic        int_ack_o,
  output logic        int_en_o,
  output logic        stk_ovf_o,
  output logic        stk_unf_o
);

  seq_state_e         state;
  seq_state_e         state_next;
  pc_sel_e            sel;
  pc_t                pc_next;
  pc_t                saved_pc;
  logic [DEPTH_W-1:0] depth;
  logic               int_en_q;
  logic               int_ack_q;
  logic               int_take;
  logic               reti_take;
  logic               reti_req;
  logic               irq;

  assign push_pc_o = pc_o + 12'd1;
  assign int_en_o  = int_en_q;
  assign int_ack_o = int_ack_q;

`ifdef PC_SEQ_INT_EN
  assign reti_req = reti_i;
  assign irq      = int_en_q & int_req_i;

  // Interrupt enable, return address capture and acknowledge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_en_q  <= 1'b0;
      int_ack_q <= 1'b0;
      saved_pc  <= '0;
    end else begin
      int_ack_q <= int_take;
      if (cen) begin
        if (int_take) begin
          saved_pc <= push_pc_o;
          int_en_q <= 1'b0;
        end else if (ien_clr_i) begin
          int_en_q <= 1'b0;
        end else if (ien_set_i || reti_take) begin
          int_en_q <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_int_inputs;

  assign reti_req          = 1'b0;
  assign irq               = 1'b0;
  assign int_en_q          = 1'b0;
  assign int_ack_q         = 1'b0;
  assign saved_pc          = '0;
  assign unused_int_inputs = &{1'b0, reti_i, ien_set_i, ien_clr_i, int_req_i};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state logic: RET_WAIT always lasts one enabled cycle
  always_comb begin
    state_next = state;
    if (cen) begin
      case (state)
        RUN:      if (ret_i) state_next = RET_WAIT;
        RET_WAIT: state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  // Output logic: control priority and stack strobes
  always_comb begin
    sel       = SEL_HOLD;
    push_o    = 1'b0;
    pop_o     = 1'b0;
    int_take  = 1'b0;
    reti_take = 1'b0;
    if (cen) begin
      case (state)
        RUN: begin
          if (ret_i) begin
            pop_o = 1'b1;
            sel   = SEL_HOLD;
          end else if (reti_req) begin
            reti_take = 1'b1;
            sel       = SEL_SAVED;
          end else if (jsb_i) begin
            push_o = 1'b1;
            sel    = SEL_TARGET;
          end else if (jmp_i) begin
            sel = SEL_TARGET;
          end else if (br_taken_i) begin
            sel = SEL_BRANCH;
          end else if (irq) begin
            int_take = 1'b1;
            sel      = SEL_INT;
          end else begin
            sel = SEL_INC;
          end
        end
        RET_WAIT: sel = SEL_STACK;
        default:  sel = SEL_HOLD;
      endcase
    end
  end

  pc_next_calc #(
    .INT_VEC (INT_VEC)
  ) u_next (
    .sel      (sel),
    .pc       (pc_o),
    .target   (target_i),
    .disp     (disp_i),
    .stack_pc (stack_pc_i),
    .saved_pc (saved_pc),
    .pc_next  (pc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pc_o <= RESET_VEC;
    else if (cen) pc_o <= pc_next;
  end

  // Return-stack depth tracking with sticky overflow/underflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth     <= '0;
      stk_ovf_o <= 1'b0;
      stk_unf_o <= 1'b0;
    end else if (push_o) begin
      if (depth == DEPTH_W'(STACK_DEPTH)) stk_ovf_o <= 1'b1;
      else                                depth     <= depth + DEPTH_W'(1);
    end else if (pop_o) begin
      if (depth == '0) stk_unf_o <= 1'b1;
      else             depth     <= depth - DEPTH_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a random run
// against a queue-based behavioural model. Honours PC_SEQ_INT_EN.
module tb_pc_sequencer;

`ifdef PC_SEQ_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif
  localparam int RST_PC = 0;
  localparam int INT_PC = 1;

  logic        clk, rst, cen;
  logic        jmp, jsb, ret, br, reti, ien_set, ien_clr, int_req;
  logic [11:0] target, stack_pc;
  logic [7:0]  disp;
  logic [11:0] pc, push_pc;
  logic        push, pop, int_ack, int_en, ovf, unf;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int  m_pc, m_ret_val, m_saved;
  int  m_stack[$];
  bit  m_wait, m_ovf, m_unf, m_ien, m_ack;
  bit  exp_push, exp_pop;
  int  exp_push_pc;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .jmp_i      (jmp),
    .jsb_i      (jsb),
    .ret_i      (ret),
    .br_taken_i (br),
    .target_i   (target),
    .disp_i     (disp),
    .reti_i     (reti),
    .ien_set_i  (ien_set),
    .ien_clr_i  (ien_clr),
    .int_req_i  (int_req),
    .stack_pc_i (stack_pc),
    .pc_o       (pc),
    .push_o     (push),
    .pop_o      (pop),
    .push_pc_o  (push_pc),
    .int_ack_o  (int_ack),
    .int_en_o   (int_en),
    .stk_ovf_o  (ovf),
    .stk_unf_o  (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cen = 1'b1; jmp = 1'b0; jsb = 1'b0; ret = 1'b0; br = 1'b0;
    reti = 1'b0; ien_set = 1'b0; ien_clr = 1'b0; int_req = 1'b0;
    target = 12'h000; disp = 8'h00; stack_pc = 12'h000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_pc = RST_PC; m_wait = 0; m_ovf = 0; m_unf = 0; m_ien = 0; m_ack = 0;
    m_saved = 0; m_ret_val = 0;
    m_stack.delete();
  endtask

  // One enabled-or-frozen cycle of the reference model from current inputs
  task automatic model_step();
    bit took, reti_hit;
    int sd;
    took = 0; reti_hit = 0;
    exp_push = 0; exp_pop = 0;
    exp_push_pc = (m_pc + 1) % 4096;
    if (!cen) begin
      m_ack = 0;
      return;
    end
    if (m_wait) begin
      m_pc = m_ret_val;
      m_wait = 0;
    end else if (ret) begin
      exp_pop = 1;
      m_wait = 1;
      if (m_stack.size() == 0) begin
        m_unf = 1;
        m_ret_val = int'($urandom_range(0, 4095));
      end else begin
        m_ret_val = m_stack.pop_back();
      end
    end else if (INT_ON && reti) begin
      m_pc = m_saved;
      reti_hit = 1;
    end else if (jsb) begin
      exp_push = 1;
      if (m_stack.size() == 8) m_ovf = 1;
      else m_stack.push_back((m_pc + 1) % 4096);
      m_pc = int'(target);
    end else if (jmp) begin
      m_pc = int'(target);
    end else if (br) begin
      sd = int'(disp);
      if (sd >= 128) sd = sd - 256;
      m_pc = (m_pc + sd + 4096) % 4096;
    end else if (INT_ON && m_ien && int_req) begin
      m_saved = (m_pc + 1) % 4096;
      m_pc = INT_PC;
      took = 1;
    end else begin
      m_pc = (m_pc + 1) % 4096;
    end
    if (INT_ON) begin
      if (took) m_ien = 0;
      else if (ien_clr) m_ien = 0;
      else if (ien_set || reti_hit) m_ien = 1;
    end
    m_ack = took;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", pc); end
    total++; if ({int_ack, int_en, ovf, unf, push, pop} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {int_ack, int_en, ovf, unf, push, pop});
    end
    rst = 1'b0;
  endtask

  task automatic test_increment();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (pc !== 12'(i)) begin bad++; $display("FAIL incr_%0d got=%h exp=%h", i, pc, 12'(i)); end
    end
  endtask

  task automatic test_call_return();
    do_reset();
    jmp = 1'b1; target = 12'h010;
    tick();
    jmp = 1'b0; jsb = 1'b1; target = 12'h200;
    #1;
    total++; if (push !== 1'b1 || push_pc !== 12'h011) begin
      bad++; $display("FAIL jsb_push got=%b/%h exp=1/011", push, push_pc);
    end
    tick();
    jsb = 1'b0;
    total++; if (pc !== 12'h200) begin bad++; $display("FAIL jsb_pc got=%h exp=200", pc); end
    ret = 1'b1; stack_pc = 12'h011;
    #1;
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL ret_pop got=%b exp=1", pop); end
    tick();
    total++; if (pc !== 12'h200) begin bad++; $display("FAIL ret_hold got=%h exp=200", pc); end
    // controls during the wait cycle must be ignored
    jsb = 1'b1; jmp = 1'b1; target = 12'h777;
    #1;
    total++; if (push !== 1'b0 || pop !== 1'b0) begin
      bad++; $display("FAIL ret_wait_strobes got=%b%b exp=00", push, pop);
    end
    tick();
    total++; if (pc !== 12'h011) begin bad++; $display("FAIL ret_pc got=%h exp=011", pc); end
    clear_inputs();
  endtask

  task automatic test_branch_wrap();
    do_reset();
    jmp = 1'b1; target = 12'h005;
    tick();
    jmp = 1'b0; br = 1'b1; disp = 8'hFA;
    tick();
    total++; if (pc !== 12'hFFF) begin bad++; $display("FAIL br_back got=%h exp=fff", pc); end
    br = 1'b0;
    tick();
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL wrap got=%h exp=000", pc); end
  endtask

  task automatic test_interrupt();
    do_reset();
    ien_set = 1'b1;
    tick();
    ien_set = 1'b0;
    if (INT_ON) begin
      total++; if (int_en !== 1'b1) begin bad++; $display("FAIL ien_set got=%b exp=1", int_en); end
      jmp = 1'b1; target = 12'h040;
      tick();
      jmp = 1'b0; int_req = 1'b1;
      tick();
      total++; if (int_ack !== 1'b1 || pc !== 12'h001 || int_en !== 1'b0) begin
        bad++; $display("FAIL int_entry got=%b/%h/%b exp=1/001/0", int_ack, pc, int_en);
      end
      tick();
      total++; if (int_ack !== 1'b0 || pc !== 12'h002) begin
        bad++; $display("FAIL int_once got=%b/%h exp=0/002", int_ack, pc);
      end
      reti = 1'b1;
      tick();
      total++; if (pc !== 12'h041 || int_en !== 1'b1) begin
        bad++; $display("FAIL reti got=%h/%b exp=041/1", pc, int_en);
      end
    end else begin
      total++; if (int_en !== 1'b0) begin bad++; $display("FAIL ien_tied got=%b exp=0", int_en); end
      int_req = 1'b1; reti = 1'b1;
      tick();
      total++; if (int_ack !== 1'b0 || pc !== 12'h002) begin
        bad++; $display("FAIL int_ignored got=%b/%h exp=0/002", int_ack, pc);
      end
    end
    clear_inputs();
  endtask

  task automatic test_stack_flags();
    do_reset();
    jsb = 1'b1; target = 12'h100;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 8) begin
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    do_reset();
    ret = 1'b1;
    #1;
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL unf_pop got=%b exp=1", pop); end
    tick();
    total++; if (unf !== 1'b1 || ovf !== 1'b0) begin
      bad++; $display("FAIL unf_set got=%b/%b exp=1/0", unf, ovf);
    end
    ret = 1'b0;
    tick();
  endtask

  task automatic test_cen_and_reset();
    do_reset();
    tick(); tick(); tick();
    cen = 1'b0; jsb = 1'b1; target = 12'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (push !== 1'b0) begin bad++; $display("FAIL cen_push_%0d got=%b exp=0", i, push); end
      tick();
      total++; if (pc !== 12'h003) begin bad++; $display("FAIL cen_hold_%0d got=%h exp=003", i, pc); end
    end
    cen = 1'b1;
    #1;
    total++; if (push !== 1'b1 || push_pc !== 12'h004) begin
      bad++; $display("FAIL cen_resume got=%b/%h exp=1/004", push, push_pc);
    end
    tick();
    total++; if (pc !== 12'h300) begin bad++; $display("FAIL cen_jsb got=%h exp=300", pc); end
    jsb = 1'b0; ret = 1'b1; stack_pc = 12'h004;
    tick();
    ret = 1'b0; stack_pc = 12'h555;
    #1 rst = 1'b1;
    #1;
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL async_rst got=%h exp=000", pc); end
    #1 rst = 1'b0;
    tick();
    total++; if (pc !== 12'h001) begin bad++; $display("FAIL rst_abandon got=%h exp=001", pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      cen     = ($urandom_range(0, 9) != 0);
      ret     = ($urandom_range(0, 9) == 0);
      reti    = ($urandom_range(0, 11) == 0);
      jsb     = ($urandom_range(0, 7) == 0);
      jmp     = ($urandom_range(0, 9) == 0);
      br      = ($urandom_range(0, 7) == 0);
      ien_set = ($urandom_range(0, 7) == 0);
      ien_clr = ($urandom_range(0, 15) == 0);
      int_req = ($urandom_range(0, 3) == 0);
      target  = 12'($urandom);
      disp    = 8'($urandom);
      stack_pc = m_wait ? 12'(m_ret_val) : 12'($urandom);
      #1;
      model_step();
      total++; if (push !== exp_push || pop !== exp_pop) begin
        bad++; $display("FAIL rnd_strobe n=%0d got=%b%b exp=%b%b", n, push, pop, exp_push, exp_pop);
      end
      if (exp_push) begin
        total++; if (push_pc !== 12'(exp_push_pc)) begin
          bad++; $display("FAIL rnd_push_pc n=%0d got=%h exp=%h", n, push_pc, 12'(exp_push_pc));
        end
      end
      tick();
      total++; if (pc !== 12'(m_pc)) begin
        bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, 12'(m_pc));
      end
      total++; if ({ovf, unf, int_en, int_ack} !== {m_ovf, m_unf, m_ien, m_ack}) begin
        bad++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {ovf, unf, int_en, int_ack},
                        {m_ovf, m_unf, m_ien, m_ack});
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_increment();
    test_call_return();
    test_branch_wrap();
    test_interrupt();
    test_stack_flags();
    test_cen_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
